// File: rtl/fp32_relu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp32_relu                                                        |
// | Function : Registered binary32 ReLU; optional leaky slope 2^-LEAKY_SHIFT    |
// |            selected by defining RELU_LEAKY_EN.                              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fp32_relu #(
  parameter int LEAKY_SHIFT = 6
) (
  input  logic [31:0] x,
  input  logic        clk,
  input  logic        en,
  output logic [31:0] out,
  input  logic        rst,
  output logic        out_valid
);

  localparam logic [31:0] c_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] c_ZERO = 32'h0000_0000;

  logic        w_s;
  logic [7:0]  w_e;
  logic [22:0] w_m;
  logic        w_is_nan;
  logic [31:0] w_neg_res;
  logic [31:0] w_res;
  logic [31:0] r_out;
  logic        r_valid;

  assign w_s      = x[31];
  assign w_e      = x[30:23];
  assign w_m      = x[22:0];
  assign w_is_nan = (w_e == 8'hFF) && (w_m != 23'd0);

`ifdef RELU_LEAKY_EN
  localparam logic [7:0] c_K = 8'(LEAKY_SHIFT);

  logic [23:0] w_full_m;
  logic [7:0]  w_nsh;
  logic [22:0] w_nrm_to_sub;
  logic [22:0] w_sub_m;

  assign w_full_m     = {1'b1, w_m};
  // Normal inputs falling below the normal range lose one extra bit to the hidden 1.
  assign w_nsh        = c_K - w_e + 8'd1;
  assign w_nrm_to_sub = 23'(w_full_m >> w_nsh);
  assign w_sub_m      = w_m >> c_K;

  always_comb begin
    w_neg_res = x;
    if (w_e == 8'hFF) begin
      w_neg_res = x;
    end else if (w_e == 8'd0) begin
      w_neg_res = {1'b1, 8'd0, w_sub_m};
    end else if (w_e > c_K) begin
      w_neg_res = {1'b1, w_e - c_K, w_m};
    end else begin
      w_neg_res = {1'b1, 8'd0, w_nrm_to_sub};
    end
  end
`else
  assign w_neg_res = c_ZERO;
`endif

  always_comb begin
    w_res = x;
    if (w_is_nan) begin
      w_res = c_QNAN;
    end else if (w_s) begin
      w_res = w_neg_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= c_ZERO;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_out <= w_res;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp32_relu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp32_relu                                                     |
// | Function : Directed-vector self-checking bench for fp32_relu.               |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fp32_relu;

  logic [31:0] x;
  logic        clk;
  logic        en;
  logic [31:0] out;
  logic        rst;
  logic        out_valid;

  int n_total = 0;
  int n_bad   = 0;

  fp32_relu #(.LEAKY_SHIFT(6)) dut (
    .x(x),
    .clk(clk),
    .en(en),
    .out(out),
    .rst(rst),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then settle just past the capturing edge.
  task automatic apply(input logic [31:0] xv, input logic env);
    @(negedge clk);
    x  = xv;
    en = env;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] xv, input logic [31:0] exp);
    apply(xv, 1'b1);
    chk(tag, out, exp);
    chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
  endtask

`ifdef RELU_LEAKY_EN
  localparam logic [31:0] c_NEG1 = 32'hBC80_0000;
  localparam logic [31:0] c_NEG0 = 32'h8000_0000;
  localparam logic [31:0] c_NINF = 32'hFF80_0000;
`else
  localparam logic [31:0] c_NEG1 = 32'h0000_0000;
  localparam logic [31:0] c_NEG0 = 32'h0000_0000;
  localparam logic [31:0] c_NINF = 32'h0000_0000;
`endif

  initial begin
    x   = 32'h3F80_0000;
    en  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out", out, 32'h0000_0000);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vec("zero", 32'h0000_0000, 32'h0000_0000);

    vec("neg_one", 32'hBF80_0000, c_NEG1);
    vec("pos_one", 32'h3F80_0000, 32'h3F80_0000);
    vec("neg_zero", 32'h8000_0000, c_NEG0);
    vec("neg_inf", 32'hFF80_0000, c_NINF);
    vec("neg_nan", 32'hFFC0_0001, 32'h7FC0_0000);
    vec("pos_snan", 32'h7F80_0001, 32'h7FC0_0000);
    vec("pos_inf", 32'h7F80_0000, 32'h7F80_0000);
    vec("pos_sub", 32'h0000_0001, 32'h0000_0001);

`ifdef RELU_LEAKY_EN
    // e=1: 2^-126 * 2^-6 = 2^-132 = 0x20000 * 2^-149
    vec("lk_e1", 32'h8080_0000, 32'h8002_0000);
    // e=6: 2^-121 * 2^-6 = 2^-127 = 0x400000 * 2^-149
    vec("lk_e6", 32'h8300_0000, 32'h8040_0000);
    vec("lk_sub", 32'h8040_0000, 32'h8001_0000);
    vec("lk_tiny", 32'h8000_0001, 32'h8000_0000);
    vec("lk_e7", 32'h8380_0000, 32'h8080_0000);
`endif

    apply(32'h4049_0FDB, 1'b1);
    chk("hold_load", out, 32'h4049_0FDB);
    for (int i = 0; i < 3; i++) begin
      apply(32'h3F80_0000, 1'b0);
      chk("hold_out", out, 32'h4049_0FDB);
      chk("hold_valid", {31'd0, out_valid}, 32'd0);
    end

    vec("strm0", 32'h3F80_0000, 32'h3F80_0000);
    vec("strm1", 32'hBF80_0000, c_NEG1);
    vec("strm2", 32'h4000_0000, 32'h4000_0000);

    // Reset mid-stream with enable held high.
    @(negedge clk);
    x   = 32'h4000_0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out", out, 32'h0000_0000);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vec("post_rst", 32'h4040_0000, 32'h4040_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
